reorder_buffer: RTL and testbench
=================================

// Module: reorder_buffer
// PURPOSE
//  In-order retirement buffer for the out-of-order core; sits beside the register status table.
//  Decode allocates one entry per instruction; its slot index is the tag written into the
//  destination register's status entry. Execution results arrive over the CDB.
//  Results retire in program order to the architectural register file.
//  The buffer forwards completed but uncommitted values to dispatch for source tags.
// PARAMETERS
//  DEPTH   64  entry count; power of two; TAG_W = $clog2(DEPTH) = 6
//  WIDTH   32  data width of a result
//  AREG_W  5   architectural register index width
// PORTS
//  clk          in   1       rising-edge clock
//  reset        in   1       synchronous, active-high reset
//  alloc_valid  in   1       decode requests an entry this cycle
//  alloc_rd     in   AREG_W  destination architectural register of the new entry
//  alloc_ready  out  1       entry available (not full, no flush)
//  alloc_tag    out  TAG_W   tag granted to the allocation this cycle (= tail index)
//  cdb_valid    in   1       result broadcast valid
//  cdb_tag      in   TAG_W   tag of the broadcast result
//  cdb_data     in   WIDTH   broadcast result value
//  src1_tag     in   TAG_W   lookup tag for source 1 (from status table)
//  src1_ready   out  1       source 1 value available
//  src1_data    out  WIDTH   source 1 value
//  src2_tag/src2_ready/src2_data  as src1, for source 2
//  commit_valid out  1       head entry retires this cycle
//  commit_rd    out  AREG_W  destination register of retiring entry
//  commit_tag   out  TAG_W   tag of retiring entry (status table clears valid only on tag match)
//  commit_data  out  WIDTH   value of retiring entry
//  flush        in   1       discard all entries
//  count        out  TAG_W+1 occupied entries, 0..DEPTH
// BEHAVIOUR
//  - Entry fields: busy, done, rd, data. Head and tail are TAG_W+1-bit pointers; the MSB is the wrap bit.
//  - Reset: all busy=0, head=tail=0, count=0. alloc_ready=1, alloc_tag=0, commit_valid=0,
//    commit_* = 0.
//  - Allocation: alloc_ready = (count != DEPTH) && !flush. alloc_tag = tail[TAG_W-1:0]
//    (combinational).
//    On alloc_valid && alloc_ready: entry[tail] <= {busy=1, done=0, rd=alloc_rd}; tail++.
//    alloc_valid while not ready is ignored; the tail does not move.
//  - Writeback: when cdb_valid && entry[cdb_tag].busy, set done<=1 and data<=cdb_data.
//    A CDB to a non-busy entry is ignored.
//  - Commit: commit_valid = entry[head].busy && entry[head].done && !flush. It is always
//    accepted; on commit, busy<=0 and head++.
//    commit_rd/tag/data are driven from the head entry when commit_valid=1, else 0.
//    rd=0 entries still commit; the consumer discards writes to x0.
//    Commit rate is 1 per cycle.
//  - Latency: CDB at cycle N makes the entry committable at N+1 at the earliest. Alloc at N
//    makes the entry visible at N+1.
//  - Source lookup (combinational): if cdb_valid && cdb_tag==srcX_tag, then ready=1 and
//    data=cdb_data (bypass).
//    Else ready = entry[srcX_tag].busy && entry[srcX_tag].done, and data = entry data.
//    When ready=0, data=0.
//  - count: next = count + alloc_fire - commit_fire.
//    Full is judged on the registered count: with count==DEPTH, alloc is refused even if a
//    commit fires that cycle.
//  - Alloc, CDB and commit may all occur in one cycle to distinct entries.
//    A CDB to the entry being committed cannot occur (the entry is already done).
//  - Flush (priority over alloc, CDB, commit): next cycle all busy=0, head=tail=0, count=0.
//    No commit occurs in the flush cycle.
//  - Reset asserted mid-operation behaves identically to flush plus output reset; pending
//    results are lost.
// STRUCTURE
//  - rob_pkg: TAG_W, rob_entry_t packed struct {busy, done, rd[AREG_W], data[WIDTH]},
//    rob_ptr_t.
//  - Sub-module rob_ptr: wrap-bit pointer register with inc/clear; instanced for head and
//    tail.
//  - Entry array is flops (multi-port read: head + 2 src); no SRAM.
// TESTING
//  1 After reset: count=0, alloc_ready=1, alloc_tag=0, commit_valid=0, src1_ready=0 for any
//    tag.
//  2 Alloc rd=3,5,7 (tags 0,1,2).
//    CDB tag1=0xAA, then tag0=0x55, then tag2=0xCC.
//    -> commits in order: (rd3,0x55), (rd5,0xAA), (rd7,0xCC) on consecutive cycles.
//    count returns to 0.
//  3 Fill 64 allocs -> alloc_ready=0, count=64.
//    Alloc attempt with a same-cycle commit of tag0 -> refused.
//    Next cycle alloc_ready=1, alloc_tag=0 (wrap), tail wrap bit toggles.
//  4 src1_tag=4 with CDB tag4=0x1234 that cycle -> src1_ready=1, src1_data=0x1234 (bypass).
//    Next cycle -> the same values from storage.
//  5 Ten entries allocated, three done; assert flush with alloc_valid=1.
//    -> no commit, no alloc; next cycle count=0, alloc_tag=0.
//    A later CDB to tag 5 is ignored.
//  6 Stray CDB tag=9 to an empty entry -> no state change.
//    Later alloc to tag 9 -> done=0, no spurious commit.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared sizing and entry/pointer types for the reorder buffer.
// Pointers carry one extra wrap bit above the slot index.
package rob_pkg;
    localparam int unsigned DEPTH  = 64;
    localparam int unsigned WIDTH  = 32;
    localparam int unsigned AREG_W = 5;
    localparam int unsigned TAG_W  = $clog2(DEPTH);
    localparam int unsigned PTR_W  = TAG_W + 1;

    typedef logic [PTR_W-1:0] rob_ptr_t;

    typedef struct packed {
        logic              busy;
        logic              done;
        logic [AREG_W-1:0] rd;
        logic [WIDTH-1:0]  data;
    } rob_entry_t;
endpackage

// File: rtl/rob_ptr.sv
// Wrap-bit pointer register with synchronous clear and increment.
module rob_ptr
    import rob_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     i_clr,
    input  logic     i_inc,
    output rob_ptr_t o_ptr
);
    rob_ptr_t r_ptr;

    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_ptr <= '0;
        end else if (i_inc) begin
            r_ptr <= r_ptr + PTR_W'(1);
        end
    end

    assign o_ptr = r_ptr;
endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocate at tail, CDB writeback, commit at head,
// with combinational source-operand forwarding (CDB bypass first, then storage).
module reorder_buffer
    import rob_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              alloc_valid,
    input  logic [AREG_W-1:0] alloc_rd,
    output logic              alloc_ready,
    output logic [TAG_W-1:0]  alloc_tag,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [WIDTH-1:0]  cdb_data,
    input  logic [TAG_W-1:0]  src1_tag,
    output logic              src1_ready,
    output logic [WIDTH-1:0]  src1_data,
    input  logic [TAG_W-1:0]  src2_tag,
    output logic              src2_ready,
    output logic [WIDTH-1:0]  src2_data,
    output logic              commit_valid,
    output logic [AREG_W-1:0] commit_rd,
    output logic [TAG_W-1:0]  commit_tag,
    output logic [WIDTH-1:0]  commit_data,
    input  logic              flush,
    output logic [TAG_W:0]    count
);
    rob_entry_t        r_entries [DEPTH];
    rob_ptr_t          w_head;
    rob_ptr_t          w_tail;
    rob_ptr_t          w_count;
    logic [TAG_W-1:0]  w_head_idx;
    logic [TAG_W-1:0]  w_tail_idx;
    logic              w_alloc_fire;
    logic              w_commit_fire;
    rob_entry_t        w_head_entry;

    rob_ptr u_head (
        .clk   (clk),
        .reset (reset),
        .i_clr (flush),
        .i_inc (w_commit_fire),
        .o_ptr (w_head)
    );

    rob_ptr u_tail (
        .clk   (clk),
        .reset (reset),
        .i_clr (flush),
        .i_inc (w_alloc_fire),
        .o_ptr (w_tail)
    );

    // Occupancy from the wrap-bit pointers; equals DEPTH exactly when full.
    assign w_count      = w_tail - w_head;
    assign count        = w_count;
    assign w_head_idx   = w_head[TAG_W-1:0];
    assign w_tail_idx   = w_tail[TAG_W-1:0];
    assign w_head_entry = r_entries[w_head_idx];

    assign alloc_ready   = (w_count != PTR_W'(DEPTH)) && !flush;
    assign alloc_tag     = w_tail_idx;
    assign w_alloc_fire  = alloc_valid && alloc_ready;
    assign w_commit_fire = w_head_entry.busy && w_head_entry.done && !flush && !reset;

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (reset) begin
                r_entries[i] <= '0;
            end else if (flush) begin
                r_entries[i].busy <= 1'b0;
                r_entries[i].done <= 1'b0;
            end else begin
                if (w_alloc_fire && (w_tail_idx == TAG_W'(i))) begin
                    r_entries[i] <= '{busy: 1'b1, done: 1'b0, rd: alloc_rd, data: '0};
                end else if (cdb_valid && (cdb_tag == TAG_W'(i)) && r_entries[i].busy) begin
                    r_entries[i].done <= 1'b1;
                    r_entries[i].data <= cdb_data;
                end
                if (w_commit_fire && (w_head_idx == TAG_W'(i))) begin
                    r_entries[i].busy <= 1'b0;
                    r_entries[i].done <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        commit_valid = 1'b0;
        commit_rd    = '0;
        commit_tag   = '0;
        commit_data  = '0;
        if (w_commit_fire) begin
            commit_valid = 1'b1;
            commit_rd    = w_head_entry.rd;
            commit_tag   = w_head_idx;
            commit_data  = w_head_entry.data;
        end
    end

    // Source forwarding: a same-cycle CDB hit wins over stored values.
    always_comb begin
        src1_ready = 1'b0;
        src1_data  = '0;
        src2_ready = 1'b0;
        src2_data  = '0;
        if (cdb_valid && (cdb_tag == src1_tag)) begin
            src1_ready = 1'b1;
            src1_data  = cdb_data;
        end else if (r_entries[src1_tag].busy && r_entries[src1_tag].done) begin
            src1_ready = 1'b1;
            src1_data  = r_entries[src1_tag].data;
        end
        if (cdb_valid && (cdb_tag == src2_tag)) begin
            src2_ready = 1'b1;
            src2_data  = cdb_data;
        end else if (r_entries[src2_tag].busy && r_entries[src2_tag].done) begin
            src2_ready = 1'b1;
            src2_data  = r_entries[src2_tag].data;
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: a vector table for in-order commit and
// forwarding, plus sequences for full/wrap, flush, stray CDB and reset.
module tb_reorder_buffer;
    logic        clk = 1'b0;
    logic        reset;
    logic        alloc_valid;
    logic [4:0]  alloc_rd;
    logic        alloc_ready;
    logic [5:0]  alloc_tag;
    logic        cdb_valid;
    logic [5:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic [5:0]  src1_tag;
    logic        src1_ready;
    logic [31:0] src1_data;
    logic [5:0]  src2_tag;
    logic        src2_ready;
    logic [31:0] src2_data;
    logic        commit_valid;
    logic [4:0]  commit_rd;
    logic [5:0]  commit_tag;
    logic [31:0] commit_data;
    logic        flush;
    logic [6:0]  count;

    int total = 0;
    int bad   = 0;

    reorder_buffer dut (
        .clk          (clk),
        .reset        (reset),
        .alloc_valid  (alloc_valid),
        .alloc_rd     (alloc_rd),
        .alloc_ready  (alloc_ready),
        .alloc_tag    (alloc_tag),
        .cdb_valid    (cdb_valid),
        .cdb_tag      (cdb_tag),
        .cdb_data     (cdb_data),
        .src1_tag     (src1_tag),
        .src1_ready   (src1_ready),
        .src1_data    (src1_data),
        .src2_tag     (src2_tag),
        .src2_ready   (src2_ready),
        .src2_data    (src2_data),
        .commit_valid (commit_valid),
        .commit_rd    (commit_rd),
        .commit_tag   (commit_tag),
        .commit_data  (commit_data),
        .flush        (flush),
        .count        (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic        cv;
        logic [5:0]  ctag;
        logic [31:0] cdata;
        logic [5:0]  s1;
        logic [5:0]  s2;
        logic        e_ar;
        logic [5:0]  e_atag;
        logic        e_cv;
        logic [4:0]  e_crd;
        logic [5:0]  e_ctag;
        logic [31:0] e_cdata;
        logic        e_s1r;
        logic [31:0] e_s1d;
        logic        e_s2r;
        logic [31:0] e_s2d;
        logic [6:0]  e_cnt;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drv(input logic av, input logic [4:0] rd, input logic cv,
                       input logic [5:0] ct, input logic [31:0] cd,
                       input logic [5:0] s1, input logic [5:0] s2, input logic fl);
        alloc_valid = av;
        alloc_rd    = rd;
        cdb_valid   = cv;
        cdb_tag     = ct;
        cdb_data    = cd;
        src1_tag    = s1;
        src2_tag    = s2;
        flush       = fl;
    endtask

    task automatic idle(input logic [5:0] s1, input logic [5:0] s2);
        drv(1'b0, 5'd0, 1'b0, 6'd0, 32'd0, s1, s2, 1'b0);
    endtask

    initial begin
        // av rd cv ctag cdata s1 s2 | ar atag cv crd ctag cdata s1r s1d s2r s2d cnt
        vecs[0] = '{0, 0, 0, 0, 0,     0, 9, 1, 0, 0, 0, 0, 0,     0, 0,     0, 0,     0};
        vecs[1] = '{1, 3, 0, 0, 0,     0, 9, 1, 0, 0, 0, 0, 0,     0, 0,     0, 0,     0};
        vecs[2] = '{1, 5, 0, 0, 0,     0, 9, 1, 1, 0, 0, 0, 0,     0, 0,     0, 0,     1};
        vecs[3] = '{1, 7, 0, 0, 0,     0, 9, 1, 2, 0, 0, 0, 0,     0, 0,     0, 0,     2};
        vecs[4] = '{0, 0, 1, 1, 'hAA,  1, 0, 1, 3, 0, 0, 0, 0,     1, 'hAA,  0, 0,     3};
        vecs[5] = '{0, 0, 1, 0, 'h55,  1, 0, 1, 3, 0, 0, 0, 0,     1, 'hAA,  1, 'h55,  3};
        vecs[6] = '{0, 0, 1, 2, 'hCC,  2, 0, 1, 3, 1, 3, 0, 'h55,  1, 'hCC,  1, 'h55,  3};
        vecs[7] = '{0, 0, 0, 0, 0,     1, 2, 1, 3, 1, 5, 1, 'hAA,  1, 'hAA,  1, 'hCC,  2};
        vecs[8] = '{0, 0, 0, 0, 0,     1, 2, 1, 3, 1, 7, 2, 'hCC,  0, 0,     1, 'hCC,  1};
        vecs[9] = '{0, 0, 0, 0, 0,     2, 9, 1, 3, 0, 0, 0, 0,     0, 0,     0, 0,     0};

        reset = 1'b1;
        idle(6'd0, 6'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // In-order commit with out-of-order writeback and forwarding
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drv(vecs[i].av, vecs[i].ard, vecs[i].cv, vecs[i].ctag, vecs[i].cdata,
                vecs[i].s1, vecs[i].s2, 1'b0);
            #1;
            chk($sformatf("v%0d alloc_ready", i), 32'(alloc_ready), 32'(vecs[i].e_ar));
            chk($sformatf("v%0d alloc_tag", i), 32'(alloc_tag), 32'(vecs[i].e_atag));
            chk($sformatf("v%0d commit_valid", i), 32'(commit_valid), 32'(vecs[i].e_cv));
            chk($sformatf("v%0d commit_rd", i), 32'(commit_rd), 32'(vecs[i].e_crd));
            chk($sformatf("v%0d commit_tag", i), 32'(commit_tag), 32'(vecs[i].e_ctag));
            chk($sformatf("v%0d commit_data", i), commit_data, vecs[i].e_cdata);
            chk($sformatf("v%0d src1_ready", i), 32'(src1_ready), 32'(vecs[i].e_s1r));
            chk($sformatf("v%0d src1_data", i), src1_data, vecs[i].e_s1d);
            chk($sformatf("v%0d src2_ready", i), 32'(src2_ready), 32'(vecs[i].e_s2r));
            chk($sformatf("v%0d src2_data", i), src2_data, vecs[i].e_s2d);
            chk($sformatf("v%0d count", i), 32'(count), 32'(vecs[i].e_cnt));
        end

        // Stray CDB to empty tag 9, then allocate tags 3..9
        @(negedge clk);
        drv(1'b0, 5'd0, 1'b1, 6'd9, 32'h99, 6'd3, 6'd3, 1'b0);
        #1;
        chk("stray cdb commit_valid", 32'(commit_valid), 32'd0);
        @(negedge clk);
        idle(6'd9, 6'd3);
        #1;
        chk("stray src1_ready", 32'(src1_ready), 32'd0);
        chk("stray count", 32'(count), 32'd0);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            drv(1'b1, 5'(k + 1), 1'b0, 6'd0, 32'd0, 6'd9, 6'd3, 1'b0);
            #1;
            chk($sformatf("seq6 alloc_tag %0d", k), 32'(alloc_tag), 32'(k + 3));
        end
        @(negedge clk);
        idle(6'd9, 6'd3);
        #1;
        chk("tag9 src1_ready", 32'(src1_ready), 32'd0);
        chk("tag9 commit_valid", 32'(commit_valid), 32'd0);
        chk("tag9 count", 32'(count), 32'd7);

        // Ten entries, heads done, then flush with a concurrent alloc request
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drv(1'b1, 5'd1, 1'b0, 6'd0, 32'd0, 6'd0, 6'd0, 1'b0);
            #1;
            chk($sformatf("seq5 alloc_tag %0d", k), 32'(alloc_tag), 32'(k + 10));
        end
        @(negedge clk);
        drv(1'b0, 5'd0, 1'b1, 6'd4, 32'h44, 6'd0, 6'd0, 1'b0);
        @(negedge clk);
        drv(1'b0, 5'd0, 1'b1, 6'd5, 32'h45, 6'd0, 6'd0, 1'b0);
        @(negedge clk);
        drv(1'b0, 5'd0, 1'b1, 6'd3, 32'h33, 6'd4, 6'd0, 1'b0);
        #1;
        chk("pre-flush src1 data", src1_data, 32'h44);
        chk("pre-flush commit_valid", 32'(commit_valid), 32'd0);
        @(negedge clk);
        drv(1'b1, 5'd2, 1'b0, 6'd0, 32'd0, 6'd0, 6'd0, 1'b1);
        #1;
        chk("flush alloc_ready", 32'(alloc_ready), 32'd0);
        chk("flush commit_valid", 32'(commit_valid), 32'd0);
        chk("flush count before", 32'(count), 32'd10);
        @(negedge clk);
        drv(1'b0, 5'd0, 1'b1, 6'd5, 32'h5555, 6'd6, 6'd6, 1'b0);
        #1;
        chk("post-flush count", 32'(count), 32'd0);
        chk("post-flush alloc_tag", 32'(alloc_tag), 32'd0);
        chk("post-flush commit_valid", 32'(commit_valid), 32'd0);
        @(negedge clk);
        idle(6'd5, 6'd3);
        #1;
        chk("flushed tag5 src1_ready", 32'(src1_ready), 32'd0);
        chk("flushed tag3 src2_ready", 32'(src2_ready), 32'd0);
        chk("flushed count", 32'(count), 32'd0);

        // Fill all 64 entries
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            drv(1'b1, 5'(k), 1'b0, 6'd0, 32'd0, 6'd0, 6'd0, 1'b0);
            #1;
            chk($sformatf("fill alloc_tag %0d", k), 32'(alloc_tag), 32'(k));
        end
        @(negedge clk);
        drv(1'b0, 5'd0, 1'b1, 6'd0, 32'h0F0F, 6'd0, 6'd0, 1'b0);
        #1;
        chk("full count", 32'(count), 32'd64);
        chk("full alloc_ready", 32'(alloc_ready), 32'd0);
        @(negedge clk);
        drv(1'b1, 5'd2, 1'b0, 6'd0, 32'd0, 6'd0, 6'd0, 1'b0);
        #1;
        chk("full+commit alloc_ready", 32'(alloc_ready), 32'd0);
        chk("full+commit commit_valid", 32'(commit_valid), 32'd1);
        chk("full+commit commit_tag", 32'(commit_tag), 32'd0);
        chk("full+commit commit_data", commit_data, 32'h0F0F);
        @(negedge clk);
        idle(6'd0, 6'd0);
        #1;
        chk("after commit count", 32'(count), 32'd63);
        chk("after commit alloc_ready", 32'(alloc_ready), 32'd1);
        chk("wrap alloc_tag", 32'(alloc_tag), 32'd0);

        // Wrap allocation plus CDB bypass on tag 4
        @(negedge clk);
        drv(1'b1, 5'd9, 1'b1, 6'd4, 32'h1234, 6'd4, 6'd4, 1'b0);
        #1;
        chk("bypass src1_ready", 32'(src1_ready), 32'd1);
        chk("bypass src1_data", src1_data, 32'h1234);
        chk("bypass src2_data", src2_data, 32'h1234);
        @(negedge clk);
        idle(6'd4, 6'd1);
        #1;
        chk("stored src1_ready", 32'(src1_ready), 32'd1);
        chk("stored src1_data", src1_data, 32'h1234);
        chk("stored src2_ready", 32'(src2_ready), 32'd0);
        chk("wrapped count", 32'(count), 32'd64);
        chk("wrapped alloc_ready", 32'(alloc_ready), 32'd0);
        chk("wrapped commit_valid", 32'(commit_valid), 32'd0);

        // Reset mid-operation discards everything
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        idle(6'd4, 6'd4);
        #1;
        chk("mid reset count", 32'(count), 32'd0);
        chk("mid reset alloc_ready", 32'(alloc_ready), 32'd1);
        chk("mid reset alloc_tag", 32'(alloc_tag), 32'd0);
        chk("mid reset src1_ready", 32'(src1_ready), 32'd0);
        chk("mid reset commit_valid", 32'(commit_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
